// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, limits and load validation for the multi-alarm clock
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  // Every digit must be decimal and the pair must form a real 24h clock time.
  function automatic logic valid_hm(input logic [1:0] h1, input logic [3:0] h0,
                                    input logic [3:0] m1, input logic [3:0] m0);
    int hh;
    int mm;
    hh = int'(h1) * 10 + int'(h0);
    mm = int'(m1) * 10 + int'(m0);
    return (h0 <= 4'd9) && (m1 <= 4'd9) && (m0 <= 4'd9) &&
           (hh <= MAX_HOUR) && (mm <= MAX_MIN);
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - seconds divider and BCD HH:MM:SS counter with load and carry chain
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  localparam int DW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      ld_time,
  input  logic      ld_ok,
  input  bcd_time_t ld_value,
  output logic      tick_1s,
  output bcd_time_t cur_time,
  output bcd_time_t next_time,
  output logic      min_rollover
);

  logic [DW-1:0] div_cnt;

  assign tick_1s      = (div_cnt == DW'(TICKS_PER_SEC - 1));
  assign min_rollover = tick_1s && !ld_time && (cur_time.s1 == 3'd5) && (cur_time.s0 == 4'd9);

  // The divider free-runs through loads so the second boundary never shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      cur_time <= '0;
    end else begin
      div_cnt <= tick_1s ? '0 : div_cnt + DW'(1);
      if (ld_time) begin
        if (ld_ok) cur_time <= ld_value;
      end else if (tick_1s) begin
        cur_time <= next_time;
      end
    end
  end

  always_comb begin
    next_time = cur_time;
    if (cur_time.s0 != 4'd9) begin
      next_time.s0 = cur_time.s0 + 4'd1;
    end else begin
      next_time.s0 = 4'd0;
      if (cur_time.s1 != 3'd5) begin
        next_time.s1 = cur_time.s1 + 3'd1;
      end else begin
        next_time.s1 = 3'd0;
        if (cur_time.m0 != 4'd9) begin
          next_time.m0 = cur_time.m0 + 4'd1;
        end else begin
          next_time.m0 = 4'd0;
          if (cur_time.m1 != 4'd5) begin
            next_time.m1 = cur_time.m1 + 4'd1;
          end else begin
            next_time.m1 = 4'd0;
            if (cur_time.h1 == 2'd2 && cur_time.h0 == 4'd3) begin
              next_time.h1 = 2'd0;
              next_time.h0 = 4'd0;
            end else if (cur_time.h0 == 4'd9) begin
              next_time.h1 = cur_time.h1 + 2'd1;
              next_time.h0 = 4'd0;
            end else begin
              next_time.h0 = cur_time.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - 24h BCD clock with alarm slots, snooze and ring timeout
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC    = 10,
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [AW-1:0]         al_sel,
  input  logic [NUM_ALARMS-1:0] AL_EN,
  input  logic                  STOP_al,
  input  logic                  SNOOZE,
  output logic                  tick_1s,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [2:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic                  Alarm,
  output logic [AW-1:0]         alarm_id,
  output logic                  ld_err
);

  bcd_time_t    cur_time, next_time, load_hm;
  bcd_time_t    slot [NUM_ALARMS];
  logic         ld_ok, ld_time_q, ld_alarm_q, min_rollover, match_hit;
  logic [AW-1:0] match_idx, id_nxt;
  logic [5:0]   min_cnt, min_cnt_nxt;
  alarm_state_t state, state_nxt;

  assign ld_ok   = valid_hm(H_in1, H_in0, M_in1, M_in0);
  assign load_hm = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0, s1: 3'd0, s0: 4'd0};

  bcd_time_counter #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_time (
    .clk          (clk),
    .reset_n      (reset_n),
    .ld_time      (LD_time),
    .ld_ok        (ld_ok),
    .ld_value     (load_hm),
    .tick_1s      (tick_1s),
    .cur_time     (cur_time),
    .next_time    (next_time),
    .min_rollover (min_rollover)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot[i] <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      ld_err     <= 1'b0;
    end else begin
      ld_time_q  <= LD_time;
      ld_alarm_q <= LD_alarm;
      ld_err     <= ((LD_time && !ld_time_q) || (LD_alarm && !ld_alarm_q)) && !ld_ok;
      if (LD_alarm && ld_ok && (int'(al_sel) < NUM_ALARMS)) slot[al_sel] <= load_hm;
    end
  end

  // Slots hold seconds=00, so a whole-struct compare is exact at a minute rollover.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (AL_EN[i] && (slot[i] == next_time)) begin
        match_hit = 1'b1;
        match_idx = AW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      alarm_id <= '0;
      min_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      alarm_id <= id_nxt;
      min_cnt  <= min_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    id_nxt      = alarm_id;
    min_cnt_nxt = min_cnt;
    case (state)
      IDLE: begin
        if (min_rollover && match_hit) begin
          state_nxt   = RINGING;
          id_nxt      = match_idx;
          min_cnt_nxt = '0;
        end
      end
      RINGING: begin
        if (STOP_al || !AL_EN[alarm_id]) begin
          state_nxt = IDLE;
        end else if (SNOOZE) begin
          state_nxt   = SNOOZED;
          min_cnt_nxt = '0;
        end else if (min_rollover) begin
          if (min_cnt == 6'(RING_TIMEOUT_MIN - 1)) state_nxt = IDLE;
          else min_cnt_nxt = min_cnt + 6'd1;
        end
      end
      SNOOZED: begin
        if (STOP_al || !AL_EN[alarm_id]) begin
          state_nxt = IDLE;
        end else if (min_rollover) begin
          if (min_cnt == 6'(SNOOZE_MIN - 1)) begin
            state_nxt   = RINGING;
            min_cnt_nxt = '0;
          end else begin
            min_cnt_nxt = min_cnt + 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Alarm  = (state == RINGING);
  assign H_out1 = cur_time.h1;
  assign H_out0 = cur_time.h0;
  assign M_out1 = cur_time.m1;
  assign M_out0 = cur_time.m0;
  assign S_out1 = cur_time.s1;
  assign S_out0 = cur_time.s0;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb/tb_multi_alarm_clock.sv - self-checking bench for multi_alarm_clock with a seconds-of-day model
module tb_multi_alarm_clock;

  localparam int TPS = 10;
  localparam int NA  = 4;
  localparam int AW  = 2;
  localparam int SNZ = 5;
  localparam int RTO = 10;
  localparam int ST_IDLE = 0;
  localparam int ST_RING = 1;
  localparam int ST_SNZ  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    H_in1 = '0;
  logic [3:0]    H_in0 = '0, M_in1 = '0, M_in0 = '0;
  logic          LD_time = 1'b0, LD_alarm = 1'b0, STOP_al = 1'b0, SNOOZE = 1'b0;
  logic [AW-1:0] al_sel = '0;
  logic [NA-1:0] AL_EN = '0;
  logic          tick_1s, Alarm, ld_err;
  logic [1:0]    H_out1;
  logic [3:0]    H_out0, M_out1, M_out0, S_out0;
  logic [2:0]    S_out1;
  logic [AW-1:0] alarm_id;
  wire  [20:0]   dut_time = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(RTO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_EN(AL_EN), .STOP_al(STOP_al),
    .SNOOZE(SNOOZE), .tick_1s(tick_1s), .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1),
    .M_out0(M_out0), .S_out1(S_out1), .S_out0(S_out0), .Alarm(Alarm), .alarm_id(alarm_id),
    .ld_err(ld_err)
  );

  // Reference model: time as seconds of day, slots as minutes of day.
  int m_div, m_tod, m_st, m_id, m_cnt;
  int m_slot [NA];
  bit m_err, p_lt, p_la;
  int t_h, t_m, t_next, t_win;
  bit t_ok, t_tick, t_roll, t_hit;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_div = 0; m_tod = 0; m_st = ST_IDLE; m_id = 0; m_cnt = 0;
      m_err = 0; p_lt = 0; p_la = 0;
      for (int i = 0; i < NA; i++) m_slot[i] = 0;
    end else begin
      t_h    = int'(H_in1) * 10 + int'(H_in0);
      t_m    = int'(M_in1) * 10 + int'(M_in0);
      t_ok   = (H_in0 <= 9) && (M_in1 <= 9) && (M_in0 <= 9) && (t_h <= 23) && (t_m <= 59);
      t_tick = (m_div == TPS - 1);
      t_roll = t_tick && !LD_time && (m_tod % 60 == 59);
      t_next = ((m_tod + 1) % 86400) / 60;
      t_hit  = 0;
      t_win  = 0;
      for (int i = NA - 1; i >= 0; i--)
        if (AL_EN[i] && m_slot[i] == t_next) begin t_hit = 1; t_win = i; end
      case (m_st)
        ST_IDLE: if (t_roll && t_hit) begin m_st = ST_RING; m_id = t_win; m_cnt = 0; end
        ST_RING: begin
          if (STOP_al || !AL_EN[m_id]) m_st = ST_IDLE;
          else if (SNOOZE) begin m_st = ST_SNZ; m_cnt = 0; end
          else if (t_roll) begin m_cnt++; if (m_cnt == RTO) m_st = ST_IDLE; end
        end
        default: begin
          if (STOP_al || !AL_EN[m_id]) m_st = ST_IDLE;
          else if (t_roll) begin m_cnt++; if (m_cnt == SNZ) begin m_st = ST_RING; m_cnt = 0; end end
        end
      endcase
      m_err = ((LD_time && !p_lt) || (LD_alarm && !p_la)) && !t_ok;
      p_lt  = LD_time;
      p_la  = LD_alarm;
      if (LD_alarm && t_ok) m_slot[al_sel] = t_h * 60 + t_m;
      if (LD_time) begin
        if (t_ok) m_tod = (t_h * 60 + t_m) * 60;
      end else if (t_tick) begin
        m_tod = (m_tod + 1) % 86400;
      end
      m_div = (m_div + 1) % TPS;
    end
  end

  function automatic logic [20:0] bcd(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [20:0] exp_time();
    return bcd(m_tod / 3600, (m_tod / 60) % 60, m_tod % 60);
  endfunction

  task automatic step(); @(negedge clk); endtask

  // Returns once n seconds have been consumed by the counter.
  task automatic wait_ticks(input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n) begin
      if (tick_1s) seen++;
      @(negedge clk);
      guard++;
      if (guard > (n + 2) * TPS) begin
        vectors++; errors++;
        $display("FAIL wait_ticks: saw %0d ticks, required %0d", seen, n);
        return;
      end
    end
  endtask

  task automatic set_hm(input int h, input int m);
    H_in1 = 2'(h / 10); H_in0 = 4'(h % 10); M_in1 = 4'(m / 10); M_in0 = 4'(m % 10);
  endtask

  task automatic load_time(input int h, input int m);
    set_hm(h, m); LD_time = 1'b1; step(); LD_time = 1'b0;
  endtask

  task automatic load_alarm(input int s, input int h, input int m);
    set_hm(h, m); al_sel = AW'(s); LD_alarm = 1'b1; step(); LD_alarm = 1'b0;
  endtask

  task automatic test_reset();
    int k = 0;
    step(); step();
    vectors++; if (dut_time !== bcd(0, 0, 0)) begin errors++; $display("FAIL reset_time: got %h want %h", dut_time, bcd(0, 0, 0)); end
    vectors++; if ({Alarm, alarm_id, tick_1s, ld_err} !== 5'b0) begin errors++; $display("FAIL reset_outs: got %b want 00000", {Alarm, alarm_id, tick_1s, ld_err}); end
    reset_n = 1'b1;
    while (!tick_1s && k < 50) begin step(); k++; end
    vectors++; if (k != TPS - 1) begin errors++; $display("FAIL first_tick: got %0d cycles want %0d", k, TPS - 1); end
  endtask

  task automatic test_rollover();
    int last = -1, cyc = 0, seen = 0, badp = 0;
    load_time(23, 59);
    vectors++; if (dut_time !== bcd(23, 59, 0)) begin errors++; $display("FAIL load_2359: got %h want %h", dut_time, bcd(23, 59, 0)); end
    while (seen < 60 && cyc < 1000) begin
      if (tick_1s) begin
        if (last >= 0 && cyc - last != TPS) badp++;
        last = cyc; seen++;
      end
      step(); cyc++;
    end
    vectors++; if (badp != 0 || seen != 60) begin errors++; $display("FAIL tick_period: bad periods %0d ticks %0d want 0 and 60", badp, seen); end
    vectors++; if (dut_time !== bcd(0, 0, 0)) begin errors++; $display("FAIL midnight: got %h want %h", dut_time, bcd(0, 0, 0)); end
  endtask

  task automatic test_match();
    load_alarm(2, 7, 30);
    load_alarm(0, 7, 30);
    AL_EN = 4'b0101;
    load_time(7, 29);
    wait_ticks(59);
    vectors++; if ({dut_time, Alarm} !== {bcd(7, 29, 59), 1'b0}) begin errors++; $display("FAIL pre_match: got %h/%b want %h/0", dut_time, Alarm, bcd(7, 29, 59)); end
    wait_ticks(1);
    vectors++; if ({dut_time, Alarm, alarm_id} !== {bcd(7, 30, 0), 1'b1, 2'd0}) begin errors++; $display("FAIL match: got %h/%b/%0d want %h/1/0", dut_time, Alarm, alarm_id, bcd(7, 30, 0)); end
  endtask

  task automatic test_snooze();
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
    vectors++; if (Alarm !== 1'b0) begin errors++; $display("FAIL snooze_off: got %b want 0", Alarm); end
    wait_ticks(299);
    vectors++; if ({dut_time, Alarm} !== {bcd(7, 34, 59), 1'b0}) begin errors++; $display("FAIL snoozing: got %h/%b want %h/0", dut_time, Alarm, bcd(7, 34, 59)); end
    wait_ticks(1);
    vectors++; if ({Alarm, alarm_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL snooze_ring: got %b/%0d want 1/0", Alarm, alarm_id); end
  endtask

  task automatic test_timeout();
    wait_ticks(599);
    vectors++; if ({dut_time, Alarm} !== {bcd(7, 44, 59), 1'b1}) begin errors++; $display("FAIL pre_timeout: got %h/%b want %h/1", dut_time, Alarm, bcd(7, 44, 59)); end
    wait_ticks(1);
    vectors++; if (Alarm !== 1'b0 || m_st != ST_IDLE) begin errors++; $display("FAIL timeout: got %b want 0", Alarm); end
    load_alarm(1, 7, 46);
    AL_EN = 4'b0010;
    wait_ticks(60);
    vectors++; if ({Alarm, alarm_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL ring_slot1: got %b/%0d want 1/1", Alarm, alarm_id); end
    STOP_al = 1'b1; SNOOZE = 1'b1; step(); STOP_al = 1'b0; SNOOZE = 1'b0;
    vectors++; if (Alarm !== 1'b0) begin errors++; $display("FAIL stop_snooze: got %b want 0", Alarm); end
    wait_ticks(300);
    vectors++; if (Alarm !== 1'b0) begin errors++; $display("FAIL stop_wins: got %b want 0", Alarm); end
  endtask

  task automatic test_ld_err();
    H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 4'd0; M_in0 = 4'd0; LD_time = 1'b1; step();
    vectors++; if ({ld_err, dut_time} !== {1'b1, exp_time()}) begin errors++; $display("FAIL err_24h: got %b/%h want 1/%h", ld_err, dut_time, exp_time()); end
    step();
    vectors++; if (ld_err !== 1'b0) begin errors++; $display("FAIL err_once: got %b want 0", ld_err); end
    LD_time = 1'b0; step();
    H_in1 = 2'd1; H_in0 = 4'd2; M_in1 = 4'd3; M_in0 = 4'hA; LD_time = 1'b1; step(); LD_time = 1'b0;
    vectors++; if ({ld_err, dut_time} !== {1'b1, exp_time()}) begin errors++; $display("FAIL err_digit: got %b/%h want 1/%h", ld_err, dut_time, exp_time()); end
    step();
    vectors++; if (ld_err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", ld_err); end
    load_alarm(3, 12, 0);
    AL_EN = 4'b1000;
    load_time(12, 0);
    wait_ticks(3);
    vectors++; if ({Alarm, dut_time} !== {1'b0, bcd(12, 0, 3)}) begin errors++; $display("FAIL load_eq_alarm: got %b/%h want 0/%h", Alarm, dut_time, bcd(12, 0, 3)); end
  endtask

  task automatic test_reset_mid_ring();
    load_alarm(0, 13, 0);
    AL_EN = 4'b0001;
    load_time(12, 59);
    wait_ticks(60);
    vectors++; if (Alarm !== 1'b1) begin errors++; $display("FAIL ring_13: got %b want 1", Alarm); end
    @(posedge clk); #2 reset_n = 1'b0; #1;
    vectors++; if ({Alarm, dut_time} !== {1'b0, bcd(0, 0, 0)}) begin errors++; $display("FAIL async_reset: got %b/%h want 0/%h", Alarm, dut_time, bcd(0, 0, 0)); end
    step(); reset_n = 1'b1; step();
  endtask

  task automatic test_random();
    int nm;
    AL_EN = 4'b1111;
    load_time(6, 58);
    for (int c = 0; c < 6000; c++) begin
      vectors++; if (dut_time !== exp_time()) begin errors++; $display("FAIL rnd_time @%0d: got %h want %h", c, dut_time, exp_time()); end
      vectors++; if (Alarm !== (m_st == ST_RING)) begin errors++; $display("FAIL rnd_alarm @%0d: got %b want %b", c, Alarm, m_st == ST_RING); end
      vectors++; if (alarm_id !== AW'(m_id)) begin errors++; $display("FAIL rnd_id @%0d: got %0d want %0d", c, alarm_id, m_id); end
      vectors++; if (tick_1s !== (m_div == TPS - 1)) begin errors++; $display("FAIL rnd_tick @%0d: got %b want %b", c, tick_1s, m_div == TPS - 1); end
      vectors++; if (ld_err !== m_err) begin errors++; $display("FAIL rnd_lderr @%0d: got %b want %b", c, ld_err, m_err); end
      LD_time  = ($urandom_range(0, 399) == 0);
      LD_alarm = ($urandom_range(0, 39) == 0);
      al_sel   = AW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        nm = (m_tod / 60 + int'($urandom_range(1, 2))) % 1440;
        set_hm(nm / 60, nm % 60);
      end else begin
        H_in1 = 2'($urandom); H_in0 = 4'($urandom); M_in1 = 4'($urandom); M_in0 = 4'($urandom);
      end
      STOP_al = ($urandom_range(0, 499) == 0);
      SNOOZE  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0) AL_EN = 4'($urandom);
      step();
    end
    LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_match();
    test_snooze();
    test_timeout();
    test_ld_err();
    test_reset_mid_ring();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
